register_pipe: RTL and testbench

REGISTER_PIPE -- requirements
Module: register_pipe

---
 rtl/register_pipe.sv | 107 ++++++++++
 tb/tb_register_pipe.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/register_pipe.sv
// register_pipe: a DEPTH-stage valid/ready register pipeline.
// Each stage has a valid bit and a data register. Stage 0 is fed from the
// input and the last stage drives the output. Empty stages soak up bubbles,
// so data can move forward while stages further ahead are stalled.
module register_pipe #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);

  // Per-stage state.
  logic [DEPTH-1:0] valid;
  logic [WIDTH-1:0] data [DEPTH];

  // ready[k] is the ready of stage k. ready[DEPTH] is the downstream ready.
  logic [DEPTH:0]   ready;

  // Valid bit and data offered to each stage by the stage behind it.
  logic [DEPTH-1:0] up_valid;
  logic [WIDTH-1:0] up_data [DEPTH];

  // Next valid bits and next occupancy when no flush or reset happens.
  logic [DEPTH-1:0] valid_next;
  logic [CW-1:0]    count_next;

  // A stage is ready when it is empty or the stage ahead of it is ready.
  // The chain runs from the output back toward the input.
  always_comb begin
    ready = '0;
    ready[DEPTH] = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      ready[k] = !valid[k] || ready[k+1];
    end
  end

  // Stage 0 takes the input port and every later stage takes its predecessor.
  always_comb begin
    up_valid = '0;
    up_valid[0] = in_valid;
    up_data[0] = in_data;
    for (int k = 1; k < DEPTH; k++) begin
      up_valid[k] = valid[k-1];
      up_data[k] = data[k-1];
    end
  end

  // A ready stage loads its predecessor's valid bit. A stalled stage holds.
  // The next occupancy is the population count of the new valid bits.
  always_comb begin
    valid_next = valid;
    count_next = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (ready[k]) begin
        valid_next[k] = up_valid[k];
      end
      if (valid_next[k]) begin
        count_next = count_next + CW'(1);
      end
    end
  end

  // Reset wins over everything else. A flush drops every valid bit but
  // leaves the data registers alone. Otherwise a data register changes only
  // when its stage is ready and real data is arriving, so empty slots do not
  // toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      count <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data[k] <= RESET_VAL;
      end
    end else if (flush) begin
      valid <= '0;
      count <= '0;
    end else begin
      valid <= valid_next;
      count <= count_next;
      for (int k = 0; k < DEPTH; k++) begin
        if (ready[k] && up_valid[k]) begin
          data[k] <= up_data[k];
        end
      end
    end
  end

  // Port outputs. A flush blocks new input for the whole flush cycle.
  always_comb begin
    in_ready  = ready[0] && !flush;
    out_valid = valid[DEPTH-1];
    out_data  = data[DEPTH-1];
  end

endmodule

// File: tb/tb_register_pipe.sv
// tb_register_pipe: self-checking bench for register_pipe (WIDTH=8, DEPTH=3).
// The reference model keeps a queue of in-flight entries together with the
// stage index each entry occupies.
module tb_register_pipe;

  localparam int         WIDTH = 8;
  localparam int         DEPTH = 3;
  localparam logic [7:0] RV    = 8'hA5;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] count;

  int total = 0;
  int bad = 0;

  // Model state: the oldest entry sits at the front of the queue.
  int         m_pos[$];
  logic [7:0] m_dat[$];
  int         m_new[$];
  logic [7:0] m_last = RV;
  bit         m_accept;
  bit         exp_in_ready;

  // Values sampled just before each rising edge.
  logic       obs_in_ready;
  logic       obs_out_valid;
  logic [7:0] obs_out_data;
  logic [7:0] got[$];

  register_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RV)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Work out where every entry will be after the next edge. An entry moves
  // forward when the slot ahead of it is free after its predecessor has moved.
  // The oldest entry in the last slot leaves when downstream is ready.
  task automatic model_plan(input logic iv, input logic ordy, input logic fl);
    int prev;
    int s;
    int n;
    m_new.delete();
    prev = DEPTH + 1;
    foreach (m_pos[i]) begin
      s = m_pos[i];
      if (s == DEPTH - 1) n = ordy ? DEPTH : s;
      else                n = (prev > s + 1) ? s + 1 : s;
      m_new.push_back(n);
      prev = n;
    end
    exp_in_ready = !fl && (prev > 0);
    m_accept = iv && exp_in_ready;
  endtask

  // Apply the planned movement on the clock edge.
  task automatic model_commit(input logic r, input logic fl, input logic [7:0] id);
    int         np[$];
    logic [7:0] nd[$];
    if (r) begin
      m_pos.delete();
      m_dat.delete();
      m_last = RV;
    end else if (fl) begin
      m_pos.delete();
      m_dat.delete();
    end else begin
      foreach (m_pos[i]) begin
        if (m_new[i] == DEPTH - 1 && m_pos[i] != DEPTH - 1) m_last = m_dat[i];
        if (m_new[i] < DEPTH) begin
          np.push_back(m_new[i]);
          nd.push_back(m_dat[i]);
        end
      end
      if (m_accept) begin
        np.push_back(0);
        nd.push_back(id);
        if (DEPTH == 1) m_last = id;
      end
      m_pos = np;
      m_dat = nd;
    end
  endtask

  function automatic logic exp_out_valid();
    return (m_pos.size() > 0) && (m_pos[0] == DEPTH - 1);
  endfunction

  // Drive one cycle, sample before the edge, then update the model after it.
  task automatic step(input logic iv, input logic [7:0] id, input logic ordy,
                      input logic fl, input logic r);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    #1;
    model_plan(iv, ordy, fl);
    obs_in_ready  = in_ready;
    obs_out_valid = out_valid;
    obs_out_data  = out_data;
    if (obs_out_valid === 1'b1 && ordy && !r) got.push_back(obs_out_data);
    @(posedge clk);
    model_commit(r, fl, id);
    #1;
  endtask

  // Two reset cycles, then check the idle state.
  task automatic test_reset();
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
    total++; if (out_data !== RV) begin bad++; $display("[TB] FAIL reset_out_data got %h want %h", out_data, RV); end
    total++; if (count !== 2'd0) begin bad++; $display("[TB] FAIL reset_count got %0d want 0", count); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  // Stream 0x01..0x10 with out_ready held high.
  task automatic test_streaming();
    int first = -1;
    got.delete();
    for (int i = 0; i < 24; i++) begin
      if (i < 16) step(1, 8'(i + 1), 1, 0, 0);
      else        step(0, 8'h00, 1, 0, 0);
      if (i < 16) begin
        total++; if (obs_in_ready !== 1'b1) begin bad++; $display("[TB] FAIL stream_in_ready step %0d got %b want 1", i, obs_in_ready); end
      end
      if (first < 0 && out_valid === 1'b1) first = i + 1;
      total++; if (out_valid !== exp_out_valid()) begin bad++; $display("[TB] FAIL stream_out_valid step %0d got %b want %b", i, out_valid, exp_out_valid()); end
      total++; if (count !== 2'(m_pos.size())) begin bad++; $display("[TB] FAIL stream_count step %0d got %0d want %0d", i, count, m_pos.size()); end
    end
    total++; if (first != 3) begin bad++; $display("[TB] FAIL stream_latency got %0d want 3", first); end
    total++; if (got.size() != 16) begin bad++; $display("[TB] FAIL stream_num_out got %0d want 16", got.size()); end
    for (int i = 0; i < got.size() && i < 16; i++) begin
      total++; if (got[i] !== 8'(i + 1)) begin bad++; $display("[TB] FAIL stream_order idx %0d got %h want %h", i, got[i], 8'(i + 1)); end
    end
  endtask

  // Fill the pipe against a stalled output, then release it.
  task automatic test_backpressure();
    logic [7:0] want[4];
    want[0] = 8'h11; want[1] = 8'h22; want[2] = 8'h33; want[3] = 8'h44;
    got.delete();
    for (int i = 0; i < 3; i++) step(1, want[i], 0, 0, 0);
    total++; if (count !== 2'd3) begin bad++; $display("[TB] FAIL bp_count got %0d want 3", count); end
    total++; if (out_data !== 8'h11) begin bad++; $display("[TB] FAIL bp_out_data got %h want 11", out_data); end
    step(1, 8'h44, 0, 0, 0);
    total++; if (obs_in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_full_in_ready got %b want 0", obs_in_ready); end
    total++; if (out_data !== 8'h11 || out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_stable got %b/%h want 1/11", out_valid, out_data); end
    step(1, 8'h44, 1, 0, 0);
    total++; if (obs_in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_release_in_ready got %b want 1", obs_in_ready); end
    for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 0, 0);
    total++; if (got.size() != 4) begin bad++; $display("[TB] FAIL bp_num_out got %0d want 4", got.size()); end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      total++; if (got[i] !== want[i]) begin bad++; $display("[TB] FAIL bp_order idx %0d got %h want %h", i, got[i], want[i]); end
    end
  endtask

  // A gap behind a stalled head entry must close up.
  task automatic test_bubble();
    got.delete();
    step(1, 8'h55, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    step(1, 8'h66, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    total++; if (count !== 2'd2) begin bad++; $display("[TB] FAIL bubble_count got %0d want 2", count); end
    total++; if (out_data !== 8'h55 || out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bubble_head got %b/%h want 1/55", out_valid, out_data); end
    step(0, 8'h00, 1, 0, 0);
    total++; if (out_data !== 8'h66 || out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bubble_advanced got %b/%h want 1/66", out_valid, out_data); end
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0, 0);
    total++; if (got.size() != 2) begin bad++; $display("[TB] FAIL bubble_num_out got %0d want 2", got.size()); end
  endtask

  // Flush a full pipe while input is offered.
  task automatic test_flush();
    got.delete();
    step(1, 8'h71, 0, 0, 0);
    step(1, 8'h72, 0, 0, 0);
    step(1, 8'h73, 0, 0, 0);
    step(1, 8'h77, 0, 1, 0);
    total++; if (obs_in_ready !== 1'b0) begin bad++; $display("[TB] FAIL flush_in_ready got %b want 0", obs_in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_out_valid got %b want 0", out_valid); end
    total++; if (count !== 2'd0) begin bad++; $display("[TB] FAIL flush_count got %0d want 0", count); end
    total++; if (out_data !== 8'h71) begin bad++; $display("[TB] FAIL flush_data_kept got %h want 71", out_data); end
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 0);
    total++; if (got.size() != 0) begin bad++; $display("[TB] FAIL flush_leak got %0d entries want 0", got.size()); end
  endtask

  // Reset while two entries are in flight.
  task automatic test_reset_midstream();
    got.delete();
    step(1, 8'h81, 0, 0, 0);
    step(1, 8'h82, 0, 0, 0);
    step(0, 8'h00, 1, 0, 1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_out_valid got %b want 0", out_valid); end
    total++; if (out_data !== RV) begin bad++; $display("[TB] FAIL midrst_out_data got %h want %h", out_data, RV); end
    total++; if (count !== 2'd0) begin bad++; $display("[TB] FAIL midrst_count got %0d want 0", count); end
    for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 0, 0);
    total++; if (got.size() != 0) begin bad++; $display("[TB] FAIL midrst_leak got %0d entries want 0", got.size()); end
  endtask

  // Random traffic with stalls, flushes and resets, checked against the model.
  task automatic test_random();
    logic       iv;
    logic       ordy;
    logic       fl;
    logic       r;
    logic [7:0] d;
    for (int i = 0; i < 400; i++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 39) == 0);
      r    = ($urandom_range(0, 99) == 0);
      d    = 8'($urandom);
      step(iv, d, ordy, fl, r);
      total++; if (obs_in_ready !== exp_in_ready) begin bad++; $display("[TB] FAIL rand_in_ready step %0d got %b want %b", i, obs_in_ready, exp_in_ready); end
      total++; if (out_valid !== exp_out_valid()) begin bad++; $display("[TB] FAIL rand_out_valid step %0d got %b want %b", i, out_valid, exp_out_valid()); end
      total++; if (out_data !== m_last) begin bad++; $display("[TB] FAIL rand_out_data step %0d got %h want %h", i, out_data, m_last); end
      total++; if (count !== 2'(m_pos.size())) begin bad++; $display("[TB] FAIL rand_count step %0d got %0d want %0d", i, count, m_pos.size()); end
    end
  endtask

  // Run every scenario in order and report.
  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
